pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central pipeline control for the 5-stage Y86-64 core. Drives stall/bubble to F,D,E,M,W pipe regs.
//  Covers load/use, ret, mispredict, exception drain, multi-cycle data-memory wait with timeout.
//  Latches sticky CPU status and keeps cycle/retire counters. Sits beside the pipe regs in the core top.
// PARAMETERS
//  CNT_W        32  width of cycle_cnt_o / retired_cnt_o (wrap modulo 2^CNT_W)
//  MEM_TIMEOUT  16  max consecutive dmem_busy_i cycles before bus error (>=1)
// PORTS
//  clk_i          in   1  core clock
//  rst_i          in   1  synchronous reset, active-high
//  D_icode_i      in   4  icode in D reg
//  d_srcA_i       in   4  decode srcA
//  d_srcB_i       in   4  decode srcB
//  E_icode_i      in   4  icode in E reg
//  E_dstM_i       in   4  dstM in E reg
//  e_cnd_i        in   1  execute condition result
//  M_icode_i      in   4  icode in M reg
//  m_stat_i       in   3  memory-stage status
//  W_icode_i      in   4  icode in W reg
//  W_stat_i       in   3  W-stage status
//  dmem_busy_i    in   1  data memory not ready; access in M must be held
//  F_stall_o/D_stall_o/E_stall_o/M_stall_o/W_stall_o  out 1 each  hold pipe reg
//  D_bubble_o/E_bubble_o/M_bubble_o/W_bubble_o        out 1 each  load NOP into pipe reg
//  e_setcc_en_o   out  1  CC write enable for execute
//  cpu_stat_o     out  3  sticky architectural status
//  halted_o       out  1  core stopped
//  cycle_cnt_o    out  CNT_W  cycles since reset while not halted
//  retired_cnt_o  out  CNT_W  instructions retired
// BEHAVIOUR
//  FSM states: RUN, MEM_WAIT, HALT. Reset -> RUN, cpu_stat_o=SAOK, halted_o=0, counters=0, wait_cnt=0.
//  Hazard terms (combinational):
//   loaduse = E_icode in {IMRMOVQ,IPOPQ} & E_dstM!=RNONE & E_dstM in {d_srcA,d_srcB}
//   ret     = IRET in {D_icode,E_icode,M_icode}
//   mispred = E_icode==IJXX & !e_cnd_i
//   exc_m   = m_stat_i in {SADR,SINS,SHLT};  exc_w = W_stat_i in {SADR,SINS,SHLT}
//  Priority, highest first: HALT > dmem_busy_i freeze > hazard rules.
//  Hazard rules (RUN, !dmem_busy_i):
//   F_stall=loaduse|ret; D_stall=loaduse; D_bubble=mispred|(!loaduse&ret);
//   E_bubble=mispred|loaduse; M_bubble=exc_m|exc_w; W_stall=exc_w; E_stall=M_stall=W_bubble=0
//   e_setcc_en_o = E_icode==IOPQ & !exc_m & !exc_w
//  Memory freeze (dmem_busy_i=1, RUN or MEM_WAIT): F,D,E,M stall=1; W_bubble=1; all other bubbles=0;
//   e_setcc_en_o=0. Combinational on dmem_busy_i (same cycle). RUN->MEM_WAIT on busy; wait_cnt counts
//   consecutive busy cycles; MEM_WAIT->RUN when busy drops (wait_cnt cleared).
//  Timeout: wait_cnt reaching MEM_TIMEOUT while busy -> next cycle HALT, cpu_stat_o<=SADR.
//  Exception retire: exc_w in RUN with !dmem_busy_i -> next cycle HALT, cpu_stat_o<=W_stat_i.
//   Timeout and exc_w same cycle: timeout wins (SADR). cpu_stat_o changes only on HALT entry.
//  HALT: all five *_stall_o=1, all bubbles=0, e_setcc_en_o=0, halted_o=1; exit only via rst_i.
//  Counters: cycle_cnt_o +1 each non-HALT cycle. retired_cnt_o +1 when W_icode_i!=INOP,
//   W_icode_i!=IHALT, !W_stall_o, !W_bubble_o, !exc_w, not HALT. Both wrap silently.
//  rst_i mid-MEM_WAIT or HALT: full return to reset values next edge; outputs are reset-state
//   combinational values in the cycle following reset.
// STRUCTURE
//  Shared package/define.v: icode constants (INOP,IHALT,IRET,IJXX,IOPQ,IMRMOVQ,IPOPQ), RNONE,
//   stat codes (SAOK=1,SHLT=2,SADR=3,SINS=4), FSM state encodings.
//  Sub-module: hazard_detect (pure combinational loaduse/ret/mispred/exc terms); FSM, counters here.
// TESTING
//  1 mrmovq E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0 for exactly 1 cycle.
//  2 ret in D, then E, then M -> F_stall=1, D_bubble=1 three cycles; ret+loaduse -> D_stall=1, D_bubble=0.
//  3 E_icode=IJXX, e_cnd=0 -> D_bubble=E_bubble=1, F_stall=0; e_cnd=1 -> no bubbles.
//  4 dmem_busy_i high 3 cycles -> F..M stall, W_bubble 3 cycles, cycle_cnt +3, retired_cnt unchanged.
//  5 busy held MEM_TIMEOUT cycles -> HALT, cpu_stat_o=3, halted_o=1, all stalls=1, counters frozen.
//  6 W_stat_i=SINS (4) with m_stat=SAOK -> M_bubble=W_stall=1, setcc=0, next HALT cpu_stat_o=4;
//    rst_i in HALT -> RUN, cpu_stat_o=1, counters=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared Y86-64 icode, register and status encodings plus
//               control FSM state encodings for the pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
    localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_HALT     = 2'd2;

    // Any status other than SAOK that stops the machine when it retires.
    function automatic logic is_exc_stat(input logic [2:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_hazard_detect
// Description : Pure combinational detection of load/use, ret, branch
//               mispredict and memory/write-back exception conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [3:0] i_d_icode,
    input  logic [3:0] i_d_src_a,
    input  logic [3:0] i_d_src_b,
    input  logic [3:0] i_e_icode,
    input  logic [3:0] i_e_dst_m,
    input  logic       i_e_cnd,
    input  logic [3:0] i_m_icode,
    input  logic [2:0] i_m_stat,
    input  logic [2:0] i_w_stat,
    output logic       o_loaduse,
    output logic       o_ret,
    output logic       o_mispred,
    output logic       o_exc_m,
    output logic       o_exc_w
);

    logic w_e_is_load;
    logic w_dst_match;

    assign w_e_is_load = (i_e_icode == IMRMOVQ) || (i_e_icode == IPOPQ);
    // RNONE never creates a dependency even if a source also reads RNONE.
    assign w_dst_match = (i_e_dst_m != RNONE) &&
                         ((i_e_dst_m == i_d_src_a) || (i_e_dst_m == i_d_src_b));

    assign o_loaduse = w_e_is_load && w_dst_match;
    assign o_ret     = (i_d_icode == IRET) || (i_e_icode == IRET) || (i_m_icode == IRET);
    assign o_mispred = (i_e_icode == IJXX) && !i_e_cnd;
    assign o_exc_m   = is_exc_stat(i_m_stat);
    assign o_exc_w   = is_exc_stat(i_w_stat);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline stall/bubble control for the 5-stage Y86-64 core with
//               data-memory wait/timeout, sticky status and event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [3:0]       W_icode_i,
    input  logic [2:0]       W_stat_i,
    input  logic             dmem_busy_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             W_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_bubble_o,
    output logic             e_setcc_en_o,
    output logic [2:0]       cpu_stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retired_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [2:0]         r_cpu_stat;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_retired_cnt;

    logic w_loaduse;
    logic w_ret;
    logic w_mispred;
    logic w_exc_m;
    logic w_exc_w;
    logic w_running;
    logic w_timeout;
    logic w_exc_retire;
    logic w_retire;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .i_d_icode (D_icode_i),
        .i_d_src_a (d_srcA_i),
        .i_d_src_b (d_srcB_i),
        .i_e_icode (E_icode_i),
        .i_e_dst_m (E_dstM_i),
        .i_e_cnd   (e_cnd_i),
        .i_m_icode (M_icode_i),
        .i_m_stat  (m_stat_i),
        .i_w_stat  (W_stat_i),
        .o_loaduse (w_loaduse),
        .o_ret     (w_ret),
        .o_mispred (w_mispred),
        .o_exc_m   (w_exc_m),
        .o_exc_w   (w_exc_w)
    );

    assign w_running = (r_state != ST_HALT);
    // The current busy cycle is the MEM_TIMEOUT-th consecutive one.
    assign w_timeout    = w_running && dmem_busy_i && (r_wait_cnt == c_WAIT_LAST);
    assign w_exc_retire = w_running && !dmem_busy_i && w_exc_w;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_timeout || w_exc_retire) begin
                    w_state_next = ST_HALT;
                end else if (dmem_busy_i) begin
                    w_state_next = ST_MEM_WAIT;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (HALT > memory freeze > hazard rules)
    // ------------------------------------------------------------------
    always_comb begin
        F_stall_o    = 1'b0;
        D_stall_o    = 1'b0;
        E_stall_o    = 1'b0;
        M_stall_o    = 1'b0;
        W_stall_o    = 1'b0;
        D_bubble_o   = 1'b0;
        E_bubble_o   = 1'b0;
        M_bubble_o   = 1'b0;
        W_bubble_o   = 1'b0;
        e_setcc_en_o = 1'b0;
        halted_o     = 1'b0;
        if (r_state == ST_HALT) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
            halted_o  = 1'b1;
        end else if (dmem_busy_i) begin
            // Hold everything up to M; W drains a NOP while the access waits.
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_stall_o  = 1'b1;
            M_stall_o  = 1'b1;
            W_bubble_o = 1'b1;
        end else begin
            F_stall_o    = w_loaduse || w_ret;
            D_stall_o    = w_loaduse;
            D_bubble_o   = w_mispred || (!w_loaduse && w_ret);
            E_bubble_o   = w_mispred || w_loaduse;
            M_bubble_o   = w_exc_m || w_exc_w;
            W_stall_o    = w_exc_w;
            e_setcc_en_o = (E_icode_i == IOPQ) && !w_exc_m && !w_exc_w;
        end
    end

    // ------------------------------------------------------------------
    // Consecutive busy-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_running || !dmem_busy_i) begin
            r_wait_cnt <= '0;
        end else if (!w_timeout) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sticky status: written only on the transition into HALT
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cpu_stat <= SAOK;
        end else if (w_timeout) begin
            r_cpu_stat <= SADR;
        end else if (w_exc_retire) begin
            r_cpu_stat <= W_stat_i;
        end
    end

    // ------------------------------------------------------------------
    // Cycle and retirement counters
    // ------------------------------------------------------------------
    assign w_retire = w_running && !W_stall_o && !W_bubble_o && !w_exc_w &&
                      (W_icode_i != INOP) && (W_icode_i != IHALT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else begin
            if (w_running) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_retire) begin
                r_retired_cnt <= r_retired_cnt + CNT_W'(1);
            end
        end
    end

    assign cpu_stat_o    = r_cpu_stat;
    assign cycle_cnt_o   = r_cycle_cnt;
    assign retired_cnt_o = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and randomized checks of pipe_hazard_ctrl against a
//               cycle-level behavioural model of the control rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [3:0]       D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, M_icode_i, W_icode_i;
    logic             e_cnd_i, dmem_busy_i;
    logic [2:0]       m_stat_i, W_stat_i;
    logic             F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o;
    logic             D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o;
    logic             e_setcc_en_o, halted_o;
    logic [2:0]       cpu_stat_o;
    logic [CNT_W-1:0] cycle_cnt_o, retired_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit          m_halt;
    int          m_busy_run;
    logic [2:0]  m_stat;
    logic [31:0] m_cyc, m_ret;
    // Model expected outputs: stalls {F,D,E,M,W}, bubbles {D,E,M,W}
    logic [4:0]  x_stall;
    logic [3:0]  x_bub;
    logic        x_setcc;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_cnd_i(e_cnd_i),
        .M_icode_i(M_icode_i), .m_stat_i(m_stat_i),
        .W_icode_i(W_icode_i), .W_stat_i(W_stat_i), .dmem_busy_i(dmem_busy_i),
        .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .E_stall_o(E_stall_o),
        .M_stall_o(M_stall_o), .W_stall_o(W_stall_o),
        .D_bubble_o(D_bubble_o), .E_bubble_o(E_bubble_o),
        .M_bubble_o(M_bubble_o), .W_bubble_o(W_bubble_o),
        .e_setcc_en_o(e_setcc_en_o), .cpu_stat_o(cpu_stat_o), .halted_o(halted_o),
        .cycle_cnt_o(cycle_cnt_o), .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_stat(input logic [2:0] s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction

    task automatic model_outputs();
        bit lu, rt, mp, em, ew;
        lu = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE) &&
             ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        rt = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        mp = (E_icode_i == IJXX) && !e_cnd_i;
        em = bad_stat(m_stat_i);
        ew = bad_stat(W_stat_i);
        if (m_halt) begin
            x_stall = 5'b11111; x_bub = 4'b0000; x_setcc = 1'b0;
        end else if (dmem_busy_i) begin
            x_stall = 5'b11110; x_bub = 4'b0001; x_setcc = 1'b0;
        end else begin
            x_stall = {lu || rt, lu, 1'b0, 1'b0, ew};
            x_bub   = {mp || (!lu && rt), mp || lu, em || ew, 1'b0};
            x_setcc = (E_icode_i == IOPQ) && !em && !ew;
        end
    endtask

    task automatic check_model();
        #1;
        model_outputs();
        chk("stalls", {27'd0, F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o}, {27'd0, x_stall});
        chk("bubbles", {28'd0, D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o}, {28'd0, x_bub});
        chk("setcc", {31'd0, e_setcc_en_o}, {31'd0, x_setcc});
        chk("halted", {31'd0, halted_o}, {31'd0, m_halt});
        chk("cpu_stat", {29'd0, cpu_stat_o}, {29'd0, m_stat});
        chk("cycle_cnt", cycle_cnt_o, m_cyc);
        chk("retired_cnt", retired_cnt_o, m_ret);
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_outputs();
        if (rst_i) begin
            m_halt = 0; m_busy_run = 0; m_stat = SAOK; m_cyc = 0; m_ret = 0;
        end else if (!m_halt) begin
            m_cyc = m_cyc + 1;
            if (!x_stall[0] && !x_bub[0] && !bad_stat(W_stat_i) &&
                W_icode_i != INOP && W_icode_i != IHALT)
                m_ret = m_ret + 1;
            if (dmem_busy_i) begin
                m_busy_run++;
                if (m_busy_run >= MEM_TIMEOUT) begin
                    m_halt = 1; m_stat = SADR;
                end
            end else begin
                m_busy_run = 0;
                if (bad_stat(W_stat_i)) begin
                    m_halt = 1; m_stat = W_stat_i;
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic cycle();
        check_model();
        advance();
    endtask

    task automatic set_idle();
        D_icode_i = INOP; E_icode_i = INOP; M_icode_i = INOP; W_icode_i = INOP;
        d_srcA_i = RNONE; d_srcB_i = RNONE; E_dstM_i = RNONE; e_cnd_i = 1'b1;
        m_stat_i = SAOK; W_stat_i = SAOK; dmem_busy_i = 1'b0;
    endtask

    function automatic logic [2:0] pick_stat(input int exc_weight);
        int r;
        r = $urandom_range(0, 99);
        if (r < exc_weight)          return 3'($urandom_range(2, 4));
        else if (r < exc_weight + 2) return 3'($urandom_range(5, 7));
        else                          return SAOK;
    endfunction

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 3);
        return (r == 0) ? 4'd3 : (r == 1) ? 4'd4 : (r == 2) ? RNONE : 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [3:0] pick_icode();
        int r;
        r = $urandom_range(0, 9);
        return (r == 0) ? IMRMOVQ : (r == 1) ? IPOPQ : (r == 2) ? IRET : (r == 3) ? IJXX :
               (r == 4) ? IOPQ : 4'($urandom_range(0, 11));
    endfunction

    logic [31:0] cyc_before, ret_before;

    initial begin
        set_idle();
        rst_i = 1'b1;
        m_halt = 0; m_busy_run = 0; m_stat = SAOK; m_cyc = 0; m_ret = 0;
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        // Reset state
        check_model();
        chk("reset_cycle", cycle_cnt_o, 32'd0);
        chk("reset_stat", {29'd0, cpu_stat_o}, {29'd0, SAOK});
        advance();

        // Load/use on srcA
        E_icode_i = IMRMOVQ; E_dstM_i = 4'd3; d_srcA_i = 4'd3;
        check_model();
        chk("lu_stall", {29'd0, F_stall_o, D_stall_o, E_bubble_o}, 32'd7);
        chk("lu_dbub", {31'd0, D_bubble_o}, 32'd0);
        advance();
        E_icode_i = INOP; E_dstM_i = RNONE;
        check_model();
        chk("lu_gone", {30'd0, F_stall_o, E_bubble_o}, 32'd0);
        advance();
        set_idle();

        // ret walking through D, E, M
        D_icode_i = IRET; check_model();
        chk("ret_d", {30'd0, F_stall_o, D_bubble_o}, 32'd3); advance();
        D_icode_i = INOP; E_icode_i = IRET; check_model();
        chk("ret_e", {30'd0, F_stall_o, D_bubble_o}, 32'd3); advance();
        E_icode_i = INOP; M_icode_i = IRET; check_model();
        chk("ret_m", {30'd0, F_stall_o, D_bubble_o}, 32'd3); advance();
        M_icode_i = INOP; W_icode_i = IRET; cycle();
        // ret together with load/use
        W_icode_i = INOP; D_icode_i = IRET; E_icode_i = IPOPQ; E_dstM_i = 4'd4; d_srcB_i = 4'd4;
        check_model();
        chk("ret_lu", {30'd0, D_stall_o, D_bubble_o}, 32'd2); advance();
        set_idle();

        // Mispredict and correct prediction
        E_icode_i = IJXX; e_cnd_i = 1'b0; check_model();
        chk("mispred", {29'd0, D_bubble_o, E_bubble_o, F_stall_o}, 32'd6); advance();
        e_cnd_i = 1'b1; check_model();
        chk("pred_ok", {30'd0, D_bubble_o, E_bubble_o}, 32'd0); advance();
        set_idle();

        // Three-cycle memory wait
        W_icode_i = IOPQ; dmem_busy_i = 1'b1;
        cyc_before = m_cyc; ret_before = m_ret;
        repeat (3) cycle();
        chk("wait_cyc", cycle_cnt_o, cyc_before + 32'd3);
        chk("wait_ret", retired_cnt_o, ret_before);
        dmem_busy_i = 1'b0;
        repeat (2) cycle();

        // Memory timeout
        dmem_busy_i = 1'b1;
        repeat (MEM_TIMEOUT) cycle();
        check_model();
        chk("to_halt", {31'd0, halted_o}, 32'd1);
        chk("to_stat", {29'd0, cpu_stat_o}, 32'd3);
        cyc_before = m_cyc;
        advance();
        dmem_busy_i = 1'b0;
        repeat (3) cycle();
        chk("to_frozen", cycle_cnt_o, cyc_before);

        // Reset out of HALT, then exception retire
        rst_i = 1'b1; cycle(); rst_i = 1'b0;
        set_idle();
        E_icode_i = IOPQ; W_icode_i = IOPQ; W_stat_i = SINS;
        check_model();
        chk("exc_w", {29'd0, M_bubble_o, W_stall_o, e_setcc_en_o}, 32'd6);
        advance();
        set_idle();
        check_model();
        chk("exc_stat", {29'd0, cpu_stat_o}, 32'd4);
        advance();
        rst_i = 1'b1; cycle(); rst_i = 1'b0;
        check_model();
        chk("rst_stat", {29'd0, cpu_stat_o}, 32'd1);
        chk("rst_cnt", cycle_cnt_o, 32'd0);
        advance();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            D_icode_i = pick_icode(); E_icode_i = pick_icode(); M_icode_i = pick_icode();
            W_icode_i = pick_icode();
            d_srcA_i = pick_reg(); d_srcB_i = pick_reg(); E_dstM_i = pick_reg();
            e_cnd_i = 1'($urandom_range(0, 1));
            m_stat_i = pick_stat(10); W_stat_i = pick_stat(3);
            if (dmem_busy_i) dmem_busy_i = ($urandom_range(0, 3) != 0);
            else             dmem_busy_i = ($urandom_range(0, 4) == 0);
            rst_i = m_halt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
